// File: rtl/board_in_edge_pio.sv
// board_in_edge_pio: Avalon-MM slave sampling a board input bus.
// Synchronizer chain, per-bit edge capture (write-1-to-clear), interrupt
// mask and registered level irq. Registers: 0 data (RO), 1 reserved,
// 2 irq_mask (R/W), 3 edge_capture (R, W1C). Read latency is one cycle.
// Optional input debouncing is compiled in with `define BOARD_IN_DEBOUNCE_EN.
module board_in_edge_pio #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [DATA_WIDTH-1:0] writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  irq
);

   // Elaboration-time parameter sanity checks
   if (DATA_WIDTH < 1 || DATA_WIDTH > 32 || SYNC_STAGES < 2 ||
       EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("board_in_edge_pio: illegal parameter value");
   end

   typedef enum logic [1:0] {
      ADDR_DATA  = 2'd0,
      ADDR_RSVD  = 2'd1,
      ADDR_MASK  = 2'd2,
      ADDR_EDGE  = 2'd3
   } addr_e;

   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] cap_q, cap_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic                  irq_q, irq_d;
   logic                  wr_en;

   // Metastability chain: stage 0 samples the raw pins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= in_port;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

`ifdef BOARD_IN_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];
   logic [CNT_W-1:0]      cnt_d [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] deb_q, deb_d;

   // Per-bit stability counters: a bit only follows the synchronized input
   // after it has disagreed with the debounced value for DEBOUNCE_CYCLES cycles
   always_comb begin
      deb_d = deb_q;
      for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
         cnt_d[b] = '0;
         if (sync_q[SYNC_STAGES-1][b] != deb_q[b]) begin
            if (cnt_q[b] == CNT_LAST) begin
               deb_d[b] = sync_q[SYNC_STAGES-1][b];
            end else begin
               cnt_d[b] = cnt_q[b] + 1'b1;
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q <= '0;
         for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   assign data_in = deb_q;
`else
   assign data_in = sync_q[SYNC_STAGES-1];
`endif

   // Edge detection against the previous data_in sample
   always_comb begin
      case (EDGE_TYPE)
         0:       edge_det = data_in & ~prev_q;
         1:       edge_det = ~data_in & prev_q;
         default: edge_det = data_in ^ prev_q;
      endcase
   end

   assign wr_en = chipselect & ~write_n;

   // Next-state for capture, mask, read mux and irq; capture set wins over W1C
   always_comb begin
      cap_d  = (cap_q & ~((wr_en && address == ADDR_EDGE) ? writedata : '0))
               | edge_det;
      mask_d = (wr_en && address == ADDR_MASK) ? writedata : mask_q;
      case (addr_e'(address))
         ADDR_DATA: rd_d = data_in;
         ADDR_MASK: rd_d = mask_q;
         ADDR_EDGE: rd_d = cap_q;
         default:   rd_d = '0;
      endcase
      irq_d = |(cap_q & mask_q);
   end

   // Register state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
         cap_q  <= '0;
         mask_q <= '0;
         rd_q   <= '0;
         irq_q  <= 1'b0;
      end else begin
         prev_q <= data_in;
         cap_q  <= cap_d;
         mask_q <= mask_d;
         rd_q   <= rd_d;
         irq_q  <= irq_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = irq_q;

endmodule
